lfsr_interval_gen: RTL and testbench

//  Pseudo-random blink-interval source for the LED3 channel of the blinker block.
//  A 16-bit Galois LFSR advances every cycle; rejection sampling keeps intervals >= MIN_INTERVAL.

---
 rtl/blink_pkg.sv | 27 ++
 rtl/lfsr_core.sv | 34 +++
 rtl/lfsr_interval_gen.sv | 146 ++++++++++++++
 tb/tb_lfsr_interval_gen.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/blink_pkg.sv
// ---------------------------------------------------------------------------
// blink_pkg
// Shared definitions for the blinker block and its interval source.
//   LFSR_W     : width of the Galois LFSR used for interval generation
//   LFSR_TAPS  : right-shift Galois tap mask
//   igen_state_t : interval generator FSM states
//   lfsr_step  : one right-shift Galois step
// ---------------------------------------------------------------------------
package blink_pkg;

  localparam int LFSR_W = 16;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    WARMUP  = 2'd0,
    DRAW    = 2'd1,
    PRESENT = 2'd2
  } igen_state_t;

  // Shift right; when the bit falling out is 1, fold the taps back in.
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] cur);
    logic [LFSR_W-1:0] shifted;
    shifted = cur >> 1;
    lfsr_step = cur[0] ? (shifted ^ LFSR_TAPS) : shifted;
  endfunction

endpackage

// File: rtl/lfsr_core.sv
// ---------------------------------------------------------------------------
// lfsr_core
// 16-bit right-shift Galois LFSR register. Steps every cycle out of reset;
// a load pulse replaces the next value with load_val instead of stepping.
// Ports:
//   clk      in   clock
//   rstbtn   in   asynchronous active-high reset (state <= SEED)
//   load     in   load load_val this cycle instead of stepping
//   load_val in   value to load (caller guarantees non-zero)
//   state    out  current LFSR value
// ---------------------------------------------------------------------------
module lfsr_core
  import blink_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              rstbtn,
  input  logic              load,
  input  logic [LFSR_W-1:0] load_val,
  output logic [LFSR_W-1:0] state
);

  always_ff @(posedge clk or posedge rstbtn) begin
    if (rstbtn) begin
      state <= SEED;
    end else if (load) begin
      state <= load_val;
    end else begin
      state <= lfsr_step(state);
    end
  end

endmodule

// File: rtl/lfsr_interval_gen.sv
// ---------------------------------------------------------------------------
// lfsr_interval_gen
// Pseudo-random blink-interval source for the LED3 channel. After a short
// warm-up, the low WIDTH bits of the LFSR are sampled once per cycle; draws
// below MIN_INTERVAL are rejected, accepted draws are offered on a
// valid/ready output and held until taken.
//
// Handshake: out_valid/out_interval are registered. Once out_valid is 1,
// out_interval is stable until a transfer (out_valid & out_ready at a rising
// edge). out_valid never depends combinationally on out_ready.
//
// Ports:
//   clk          in   clock
//   rstbtn       in   asynchronous active-high reset
//   seed_load    in   one-cycle pulse: reseed LFSR from seed_in, go to DRAW
//   seed_in      in   new seed (0 is replaced by SEED)
//   out_ready    in   consumer accepts out_interval this cycle
//   out_valid    out  out_interval holds an accepted draw
//   out_interval out  interval value (>= MIN_INTERVAL while out_valid)
//   fsm_state    out  debug view of the FSM state
//   reject_cnt   out  saturating count of rejected draws
//                     (present only when LFSR_REJECT_CNT_EN is defined)
// ---------------------------------------------------------------------------
module lfsr_interval_gen
  import blink_pkg::*;
#(
  parameter int                WIDTH         = 4,
  parameter logic [LFSR_W-1:0] SEED          = 16'hACE1,
  parameter int                MIN_INTERVAL  = 2,
  parameter int                WARMUP_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rstbtn,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed_in,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [WIDTH-1:0]  out_interval,
  output igen_state_t       fsm_state
`ifdef LFSR_REJECT_CNT_EN
  ,
  output logic [7:0]        reject_cnt
`endif
);

  localparam logic [7:0]       WARM_LAST = 8'(WARMUP_CYCLES - 1);
  localparam logic [WIDTH-1:0] MIN_VAL   = WIDTH'(MIN_INTERVAL);

  igen_state_t       state_q, state_d;
  logic [7:0]        warm_cnt, warm_d;
  logic              valid_d;
  logic [WIDTH-1:0]  interval_d;
  logic              reject;
  logic [LFSR_W-1:0] lfsr;
  logic [LFSR_W-1:0] load_val;
  logic [WIDTH-1:0]  raw;

  // A zero seed would lock the LFSR, so it is replaced by the reset seed.
  assign load_val = (seed_in == '0) ? SEED : seed_in;

  lfsr_core #(
    .SEED (SEED)
  ) u_lfsr (
    .clk      (clk),
    .rstbtn   (rstbtn),
    .load     (seed_load),
    .load_val (load_val),
    .state    (lfsr)
  );

  // Sample the current LFSR value, before this cycle's step.
  assign raw = lfsr[WIDTH-1:0];

  always_comb begin
    state_d    = state_q;
    warm_d     = warm_cnt;
    valid_d    = out_valid;
    interval_d = out_interval;
    reject     = 1'b0;

    case (state_q)
      WARMUP: begin
        warm_d = warm_cnt + 8'd1;
        if (warm_cnt == WARM_LAST) begin
          state_d = DRAW;
        end
      end
      DRAW: begin
        if (raw >= MIN_VAL) begin
          interval_d = raw;
          valid_d    = 1'b1;
          state_d    = PRESENT;
        end else begin
          reject = 1'b1;
        end
      end
      PRESENT: begin
        if (out_ready) begin
          valid_d = 1'b0;
          state_d = DRAW;
        end
      end
      default: begin
        state_d = WARMUP;
        valid_d = 1'b0;
      end
    endcase

    // Reseed wins over everything; a coincident transfer is still consumed
    // because out_valid drops either way.
    if (seed_load) begin
      valid_d = 1'b0;
      state_d = DRAW;
      reject  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rstbtn) begin
    if (rstbtn) begin
      state_q      <= WARMUP;
      warm_cnt     <= '0;
      out_valid    <= 1'b0;
      out_interval <= '0;
    end else begin
      state_q      <= state_d;
      warm_cnt     <= warm_d;
      out_valid    <= valid_d;
      out_interval <= interval_d;
    end
  end

  assign fsm_state = state_q;

`ifdef LFSR_REJECT_CNT_EN
  always_ff @(posedge clk or posedge rstbtn) begin
    if (rstbtn) begin
      reject_cnt <= '0;
    end else if (seed_load) begin
      reject_cnt <= '0;
    end else if (reject && (reject_cnt != 8'hFF)) begin
      reject_cnt <= reject_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_lfsr_interval_gen.sv
// ---------------------------------------------------------------------------
// tb_lfsr_interval_gen
// Directed bench for lfsr_interval_gen with hand-computed LFSR sequences.
// Inputs change 1 ns after a rising edge; outputs are checked at that point.
// ---------------------------------------------------------------------------
module tb_lfsr_interval_gen;
  import blink_pkg::*;

  logic        clk = 1'b0;
  logic        rstbtn = 1'b1;
  logic        seed_load = 1'b0;
  logic [15:0] seed_in = 16'h0000;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [3:0]  out_interval;
  igen_state_t fsm_state;
`ifdef LFSR_REJECT_CNT_EN
  logic [7:0]  reject_cnt;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  lfsr_interval_gen dut (
    .clk          (clk),
    .rstbtn       (rstbtn),
    .seed_load    (seed_load),
    .seed_in      (seed_in),
    .out_ready    (out_ready),
    .out_valid    (out_valid),
    .out_interval (out_interval),
    .fsm_state    (fsm_state)
`ifdef LFSR_REJECT_CNT_EN
    ,
    .reject_cnt   (reject_cnt)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // test 0: values while reset is held
  task automatic test_reset();
    rstbtn = 1'b1;
    tick();
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_valid: got %b expected 0", out_valid);
    end
    tests_run++;
    if (out_interval !== 4'd0) begin
      tests_failed++;
      $display("FAIL reset_interval: got %0d expected 0", out_interval);
    end
    tests_run++;
    if (dut.u_lfsr.state !== 16'hACE1) begin
      tests_failed++;
      $display("FAIL reset_lfsr: got %h expected ace1", dut.u_lfsr.state);
    end
    tests_run++;
    if (fsm_state !== WARMUP) begin
      tests_failed++;
      $display("FAIL reset_state: got %0d expected %0d", fsm_state, WARMUP);
    end
`ifdef LFSR_REJECT_CNT_EN
    tests_run++;
    if (reject_cnt !== 8'd0) begin
      tests_failed++;
      $display("FAIL reset_reject_cnt: got %0d expected 0", reject_cnt);
    end
`endif
  endtask

  // test 1: release reset, four warm-up steps, then present 14
  task automatic test_warmup();
    logic [15:0] exp_lfsr [4];
    exp_lfsr[0] = 16'hE270;
    exp_lfsr[1] = 16'h7138;
    exp_lfsr[2] = 16'h389C;
    exp_lfsr[3] = 16'h1C4E;
    out_ready = 1'b0;
    seed_load = 1'b0;
    rstbtn    = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      tests_run++;
      if (dut.u_lfsr.state !== exp_lfsr[i] || out_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL warmup_step%0d: got lfsr %h valid %b expected lfsr %h valid 0",
                 i + 1, dut.u_lfsr.state, out_valid, exp_lfsr[i]);
      end
    end
    tests_run++;
    if (fsm_state !== DRAW) begin
      tests_failed++;
      $display("FAIL warmup_to_draw: got state %0d expected %0d", fsm_state, DRAW);
    end
    tick();
    tests_run++;
    if (out_valid !== 1'b1 || out_interval !== 4'd14 || dut.u_lfsr.state !== 16'h0E27) begin
      tests_failed++;
      $display("FAIL warmup_first_draw: got valid %b interval %0d lfsr %h expected valid 1 interval 14 lfsr 0e27",
               out_valid, out_interval, dut.u_lfsr.state);
    end
  endtask

  // test 2: output held stable while out_ready stays low
  task automatic test_hold();
    int bad = 0;
    out_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (out_valid !== 1'b1 || out_interval !== 4'd14) bad++;
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL hold_stable: got %0d unstable cycles (last valid %b interval %0d) expected 0",
               bad, out_valid, out_interval);
    end
  endtask

  // test 6: asynchronous reset while presenting, then test 1 repeats
  task automatic test_async_reset();
    #2;
    rstbtn = 1'b1;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || out_interval !== 4'd0 || dut.u_lfsr.state !== 16'hACE1) begin
      tests_failed++;
      $display("FAIL async_reset: got valid %b interval %0d lfsr %h expected valid 0 interval 0 lfsr ace1",
               out_valid, out_interval, dut.u_lfsr.state);
    end
    tick();
    test_warmup();
  endtask

  // test 3: one transfer, next draw presents 3
  task automatic test_transfer();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tests_run++;
    if (out_valid !== 1'b0 || dut.u_lfsr.state !== 16'hB313 || fsm_state !== DRAW) begin
      tests_failed++;
      $display("FAIL transfer_edge: got valid %b lfsr %h state %0d expected valid 0 lfsr b313 state %0d",
               out_valid, dut.u_lfsr.state, fsm_state, DRAW);
    end
    tick();
    tests_run++;
    if (out_valid !== 1'b1 || out_interval !== 4'd3) begin
      tests_failed++;
      $display("FAIL transfer_next: got valid %b interval %0d expected valid 1 interval 3",
               out_valid, out_interval);
    end
  endtask

  // test 4: reseed with 0001, eight rejects then 8
  task automatic test_reseed_one();
    logic [15:0] exp_lfsr [9];
    exp_lfsr[0] = 16'hB400;
    exp_lfsr[1] = 16'h5A00;
    exp_lfsr[2] = 16'h2D00;
    exp_lfsr[3] = 16'h1680;
    exp_lfsr[4] = 16'h0B40;
    exp_lfsr[5] = 16'h05A0;
    exp_lfsr[6] = 16'h02D0;
    exp_lfsr[7] = 16'h0168;
    seed_in   = 16'h0001;
    seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    tests_run++;
    if (out_valid !== 1'b0 || dut.u_lfsr.state !== 16'h0001 || fsm_state !== DRAW) begin
      tests_failed++;
      $display("FAIL reseed1_load: got valid %b lfsr %h state %0d expected valid 0 lfsr 0001 state %0d",
               out_valid, dut.u_lfsr.state, fsm_state, DRAW);
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      tests_run++;
      if (out_valid !== 1'b0 || dut.u_lfsr.state !== exp_lfsr[i]) begin
        tests_failed++;
        $display("FAIL reseed1_reject%0d: got valid %b lfsr %h expected valid 0 lfsr %h",
                 i + 1, out_valid, dut.u_lfsr.state, exp_lfsr[i]);
      end
    end
    tick();
    tests_run++;
    if (out_valid !== 1'b1 || out_interval !== 4'd8) begin
      tests_failed++;
      $display("FAIL reseed1_present: got valid %b interval %0d expected valid 1 interval 8",
               out_valid, out_interval);
    end
`ifdef LFSR_REJECT_CNT_EN
    tests_run++;
    if (reject_cnt !== 8'd8) begin
      tests_failed++;
      $display("FAIL reseed1_reject_cnt: got %0d expected 8", reject_cnt);
    end
`endif
  endtask

  // test 5: reseed with 0 acts as ACE1 without warm-up
  task automatic test_reseed_zero();
    seed_in   = 16'h0000;
    seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    tests_run++;
    if (out_valid !== 1'b0 || dut.u_lfsr.state !== 16'hACE1 || fsm_state !== DRAW) begin
      tests_failed++;
      $display("FAIL reseed0_load: got valid %b lfsr %h state %0d expected valid 0 lfsr ace1 state %0d",
               out_valid, dut.u_lfsr.state, fsm_state, DRAW);
    end
`ifdef LFSR_REJECT_CNT_EN
    tests_run++;
    if (reject_cnt !== 8'd0) begin
      tests_failed++;
      $display("FAIL reseed0_cnt_clear: got %0d expected 0", reject_cnt);
    end
`endif
    tick();
    tick();
    tests_run++;
    if (out_valid !== 1'b0 || dut.u_lfsr.state !== 16'h7138) begin
      tests_failed++;
      $display("FAIL reseed0_rejects: got valid %b lfsr %h expected valid 0 lfsr 7138",
               out_valid, dut.u_lfsr.state);
    end
    tick();
    tests_run++;
    if (out_valid !== 1'b1 || out_interval !== 4'd8) begin
      tests_failed++;
      $display("FAIL reseed0_present: got valid %b interval %0d expected valid 1 interval 8",
               out_valid, out_interval);
    end
`ifdef LFSR_REJECT_CNT_EN
    tests_run++;
    if (reject_cnt !== 8'd2) begin
      tests_failed++;
      $display("FAIL reseed0_reject_cnt: got %0d expected 2", reject_cnt);
    end
`endif
  endtask

  // seed_load coinciding with a transfer: reseed wins, valid drops
  task automatic test_back_to_back();
    seed_in   = 16'h0001;
    seed_load = 1'b1;
    out_ready = 1'b1;
    tick();
    seed_load = 1'b0;
    out_ready = 1'b0;
    tests_run++;
    if (out_valid !== 1'b0 || dut.u_lfsr.state !== 16'h0001 || fsm_state !== DRAW) begin
      tests_failed++;
      $display("FAIL load_with_transfer: got valid %b lfsr %h state %0d expected valid 0 lfsr 0001 state %0d",
               out_valid, dut.u_lfsr.state, fsm_state, DRAW);
    end
    // Present 8 again after the same eight rejects, then check it holds.
    for (int i = 0; i < 9; i++) tick();
    tick();
    tests_run++;
    if (out_valid !== 1'b1 || out_interval !== 4'd8 || fsm_state !== PRESENT) begin
      tests_failed++;
      $display("FAIL load_with_transfer_present: got valid %b interval %0d state %0d expected valid 1 interval 8 state %0d",
               out_valid, out_interval, fsm_state, PRESENT);
    end
  endtask

  initial begin
    test_reset();
    test_warmup();
    test_hold();
    test_async_reset();
    test_transfer();
    test_reseed_one();
    test_reseed_zero();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
